rom_addr_seq: RTL and testbench
===============================

# rom_addr_seq

Address sequencer that drives the 5-bit `address` input of the LED sequence ROM stage. It steps through a programmable window of ROM entries [`lo`, `hi`] at a rate set by a clock prescaler, either upward or downward, and either looping or stopping once.
- Address changes only on rising `clk` edges, so a ROM stage that samples on the falling edge always sees a stable address.

## Interface
- `DIVISOR`, default 12000000: clock cycles per address step (1 s at 12 MHz). Legal range ≥1. Prescaler width is $clog2(DIVISOR), minimum 1.
- `AW`, default 5: address width, matching the ROM depth of 32.
- `clk`  in  1  system clock. One clock only.
- `rstn`  in  1  reset, asynchronous, active-low.
- `run`  in  1  level input. 1 = advance, 0 = pause/idle.
- `dir`  in  1  0 = count up toward `hi`, 1 = count down toward `lo`.
- `oneshot`  in  1  0 = wrap at end of window, 1 = stop at end of window.
- `restart`  in  1  single-cycle synchronous pulse. Reload the start address and clear done.
- `lo`  in  AW  lower window bound.
- `hi`  in  AW  upper window bound.
- `address`  out  AW  ROM address. Registered.
- `tick`  out  1  one-cycle pulse in the cycle after each address change caused by a step.
- `done`  out  1  high while stopped at the end of a oneshot run.

## Operation
- Start address `S`: `lo` when `dir`=0, `hi` when `dir`=1. `S` is evaluated in the cycle it is loaded.
- States:
  - IDLE: the reset state.
  - RUN: the prescaler counts.
  - PAUSE: the prescaler and address are held.
  - DONE: the address is held and `done`=1.
- Reset (asynchronous, `rstn`=0): IDLE, prescaler=0, `address`=0, `tick`=0, `done`=0. This takes effect immediately, including mid-run.
- IDLE, `run`=1: load `address`=S, clear the prescaler, go to RUN.
- RUN, `run`=0: go to PAUSE. The prescaler value is kept.
- PAUSE, `run`=1: go to RUN. Counting resumes from the kept value.
- RUN prescaler: increments every cycle. At DIVISOR-1 it produces a step and returns to 0.
- Step with `dir`=0:
  - If `address`≥`hi` (end of window): with `oneshot`=0, set `address`=`lo` and `tick`=1. With `oneshot`=1, go to DONE, `done`=1, no tick, address unchanged.
  - Otherwise `address`+1 and `tick`=1.
- Step with `dir`=1: mirror image. End of window is `address`≤`lo`. Wrap target is `hi`. Otherwise `address`-1.
- The "≥ / ≤" end test keeps the address inside the window when `lo`/`hi` change mid-run.
- `lo`>`hi`: every step is an end-of-window step, so the address alternates or sticks at the wrap target. No error flag.
- `dir` and `oneshot` changes take effect at the next step. No reload occurs.
- DONE is left only by `restart` or reset. `run` has no effect in DONE.
- `restart`, from any state:
  - Clears `done` and the prescaler and loads `address`=S.
  - Next state is RUN if `run`=1, else IDLE.
  - Has priority over a coincident step: no tick, no DONE entry.
- Address arithmetic wraps modulo 2^AW, which is unreachable under the end test.

## Timing
- IDLE→RUN: `address`=S is visible after the edge where `run`=1 is sampled.
- First step occurs DIVISOR cycles after entering RUN. Subsequent steps are every DIVISOR cycles while in RUN.
- Pause time is excluded from the step period. Time already accumulated before the pause is kept.
- `tick` is high for exactly one cycle, registered together with the new address.
- `done` rises in the cycle the terminal step would have occurred.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Async reset (DIVISOR=4): assert `rstn`=0 mid-run between clock edges → `address`=0, `tick`=0, `done`=0 before the next edge. After release, the block stays in IDLE until `run`=1.
- Loop up (DIVISOR=4, lo=0, hi=3, dir=0, oneshot=0, run=1): `address` sequence 0,1,2,3,0,1 with exactly 4 cycles between changes. `tick` pulses once per change, including the 3→0 wrap.
- Oneshot down (DIVISOR=4, lo=2, hi=5, dir=1, oneshot=1): sequence 5,4,3,2. Four cycles after reaching 2, `done`=1, `address` holds 2, no further ticks. Then `restart` with `run`=1 → `address`=5, `done`=0.
- Pause (DIVISOR=4, loop up from 0): drop `run` after 2 prescaler counts for 10 cycles → `address` stays 0. The next step occurs 2 cycles after `run` returns high.
- Restart collision (DIVISOR=4, address 2, lo=0, dir=0): pulse `restart` in the cycle of the terminal count → `address`=0, `tick`=0. The next step occurs 4 cycles later.
- Bounds change (DIVISOR=4, lo=0, hi=15, looping up, address 7): set hi=5 → next step gives `address`=0 with `tick`=1.

Source files
------------

// File: rtl/rom_addr_seq_if.sv
// Control/status bundle between a sequencer client and rom_addr_seq.
// The client drives the window and mode controls; the sequencer returns the registered address.
interface rom_addr_seq_if #(
    parameter int unsigned AW = 5
);
    logic          run;
    logic          dir;
    logic          oneshot;
    logic          restart;
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    logic [AW-1:0] address;
    logic          tick;
    logic          done;

    modport master (
        output run, dir, oneshot, restart, lo, hi,
        input  address, tick, done
    );

    modport slave (
        input  run, dir, oneshot, restart, lo, hi,
        output address, tick, done
    );
endinterface

// File: rtl/rom_addr_seq.sv
// Steps a ROM address through the window [lo, hi] once every DIVISOR clocks,
// up or down, looping or stopping once. All outputs are registered.
module rom_addr_seq #(
    parameter int unsigned DIVISOR = 12000000,
    parameter int unsigned AW      = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    rom_addr_seq_if.slave   bus
);
    localparam int unsigned PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [PW-1:0] LastCnt = PW'(DIVISOR - 1);
    localparam logic [PW-1:0] CntOne  = PW'(1);
    localparam logic [AW-1:0] AddrOne = AW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    logic [AW-1:0] start_addr;
    logic          at_end;

    // Start and wrap targets coincide: lo going up, hi going down.
    assign start_addr = bus.dir ? bus.hi : bus.lo;
    // Inclusive compare keeps the address in-window if the bounds move under it.
    assign at_end     = bus.dir ? (addr_q <= bus.lo) : (addr_q >= bus.hi);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        addr_d  = addr_q;
        tick_d  = 1'b0;
        done_d  = done_q;

        if (bus.restart) begin
            // Restart wins over a coincident step: no tick, no DONE entry.
            presc_d = '0;
            addr_d  = start_addr;
            done_d  = 1'b0;
            state_d = bus.run ? StRun : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.run) begin
                        addr_d  = start_addr;
                        presc_d = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!bus.run) begin
                        state_d = StPause;
                    end else if (presc_q == LastCnt) begin
                        presc_d = '0;
                        if (at_end) begin
                            if (bus.oneshot) begin
                                state_d = StDone;
                                done_d  = 1'b1;
                            end else begin
                                addr_d = start_addr;
                                tick_d = 1'b1;
                            end
                        end else begin
                            addr_d = bus.dir ? (addr_q - AddrOne) : (addr_q + AddrOne);
                            tick_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + CntOne;
                    end
                end
                StPause: begin
                    if (bus.run) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            presc_q <= '0;
            addr_q  <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            addr_q  <= addr_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign bus.address = addr_q;
    assign bus.tick    = tick_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_rom_addr_seq.sv
// Bench for rom_addr_seq: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a cycle-count reference model.
module tb_rom_addr_seq;
    localparam int unsigned DIV = 4;
    localparam int unsigned AW  = 5;

    logic clk;
    logic rst_ni;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 0;

    rom_addr_seq_if #(.AW(AW)) bus ();

    rom_addr_seq #(.DIVISOR(DIV), .AW(AW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: "loaded" = sequence has been started, "running" = run was high
    // last cycle, "elapsed" = active cycles since the last step.
    typedef struct packed {
        logic          loaded;
        logic          running;
        logic          done;
        logic          tick;
        logic [AW-1:0] addr;
        int            elapsed;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t cur);
        mstate_t n;
        int      s;
        int      a;
        n      = cur;
        n.tick = 1'b0;
        s      = bus.dir ? int'(bus.hi) : int'(bus.lo);
        a      = int'(cur.addr);
        if (bus.restart) begin
            n.addr    = AW'(s);
            n.elapsed = 0;
            n.done    = 1'b0;
            n.loaded  = bus.run;
            n.running = bus.run;
        end else if (cur.done) begin
            n = cur;
            n.tick = 1'b0;
        end else if (!cur.loaded) begin
            if (bus.run) begin
                n.loaded  = 1'b1;
                n.running = 1'b1;
                n.addr    = AW'(s);
                n.elapsed = 0;
            end
        end else begin
            if (cur.running && bus.run) begin
                if (cur.elapsed + 1 == int'(DIV)) begin
                    n.elapsed = 0;
                    if ((!bus.dir && a >= int'(bus.hi)) || (bus.dir && a <= int'(bus.lo))) begin
                        if (bus.oneshot) n.done = 1'b1;
                        else begin
                            n.addr = AW'(s);
                            n.tick = 1'b1;
                        end
                    end else begin
                        n.addr = bus.dir ? AW'(a - 1) : AW'(a + 1);
                        n.tick = 1'b1;
                    end
                end else begin
                    n.elapsed = cur.elapsed + 1;
                end
            end
            n.running = bus.run;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) m <= '0;
        else         m <= model_next(m);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_addr", int'(bus.address), int'(m.addr));
            check("model_tick", int'(bus.tick), int'(m.tick));
            check("model_done", int'(bus.done), int'(m.done));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_ni      = 1'b0;
        bus.run     = 1'b0;
        bus.restart = 1'b0;
        @(negedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic setup(input int lo, input int hi, input bit dir, input bit os);
        bus.lo      = AW'(lo);
        bus.hi      = AW'(hi);
        bus.dir     = dir;
        bus.oneshot = os;
        bus.run     = 1'b1;
    endtask

    int exp_up[6] = '{0, 1, 2, 3, 0, 1};
    int exp_dn[4] = '{5, 4, 3, 2};

    initial begin
        rst_ni = 1'b1;
        bus.run = 1'b0; bus.dir = 1'b0; bus.oneshot = 1'b0; bus.restart = 1'b0;
        bus.lo = '0; bus.hi = '0;
        #2 rst_ni = 1'b0;
        #1;
        check("reset_addr", int'(bus.address), 0);
        check("reset_tick", int'(bus.tick), 0);
        check("reset_done", int'(bus.done), 0);
        @(negedge clk);
        #1 rst_ni = 1'b1;
        cmp_en = 1;

        // Loop up over [0,3]
        setup(0, 3, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("loop_addr", int'(bus.address), exp_up[i]);
            check("loop_tick", int'(bus.tick), (i > 0) ? 1 : 0);
            repeat (DIV) @(negedge clk);
        end

        // Async reset mid-run, then stay idle until run
        do_reset();
        setup(3, 6, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check("async_pre_addr", int'(bus.address), 4);
        #2 rst_ni = 1'b0;
        #1;
        check("async_addr", int'(bus.address), 0);
        check("async_tick", int'(bus.tick), 0);
        check("async_done", int'(bus.done), 0);
        @(negedge clk);
        #1 rst_ni = 1'b1;
        bus.run = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_hold_addr", int'(bus.address), 0);
        bus.run = 1'b1;
        @(negedge clk);
        check("idle_start_addr", int'(bus.address), 3);

        // Oneshot down over [2,5]
        do_reset();
        setup(2, 5, 1'b1, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("down_addr", int'(bus.address), exp_dn[i]);
            check("down_done", int'(bus.done), 0);
            repeat (DIV) @(negedge clk);
        end
        check("os_done", int'(bus.done), 1);
        check("os_addr", int'(bus.address), 2);
        check("os_tick", int'(bus.tick), 0);
        repeat (8) @(negedge clk);
        check("os_hold_done", int'(bus.done), 1);
        check("os_hold_addr", int'(bus.address), 2);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check("os_restart_addr", int'(bus.address), 5);
        check("os_restart_done", int'(bus.done), 0);

        // Pause keeps accumulated prescaler time
        do_reset();
        setup(0, 15, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.run = 1'b0;
        repeat (10) @(negedge clk);
        check("pause_addr", int'(bus.address), 0);
        bus.run = 1'b1;
        repeat (2) @(negedge clk);
        check("pause_resume_hold", int'(bus.address), 0);
        @(negedge clk);
        check("pause_step_addr", int'(bus.address), 1);
        check("pause_step_tick", int'(bus.tick), 1);

        // Restart coinciding with terminal count
        do_reset();
        setup(0, 15, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        check("coll_pre_addr", int'(bus.address), 2);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check("coll_addr", int'(bus.address), 0);
        check("coll_tick", int'(bus.tick), 0);
        repeat (3) @(negedge clk);
        check("coll_wait_addr", int'(bus.address), 0);
        @(negedge clk);
        check("coll_step_addr", int'(bus.address), 1);

        // Upper bound pulled below the current address
        do_reset();
        setup(0, 15, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        check("bounds_pre_addr", int'(bus.address), 7);
        bus.hi = AW'(5);
        repeat (DIV) @(negedge clk);
        check("bounds_addr", int'(bus.address), 0);
        check("bounds_tick", int'(bus.tick), 1);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 499) == 0) rst_ni = 1'b0;
            else rst_ni = 1'b1;
            bus.run     = ($urandom_range(0, 99) < 85);
            bus.restart = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) bus.dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.oneshot = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) bus.lo = AW'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) bus.hi = AW'($urandom_range(4, 31));
        end
        @(negedge clk);
        #1 rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
